asic_ram_nrmw: RTL and testbench

- Parametrised multi-read, multi-write register-file RAM, ASIC/simulator only; successor to the fixed 6-read/1-write 16-entry array.
- Generalises width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass, an optional registered read stage, a hardwired-zero entry 0, and a sequential background clear engine.
- Sits under the integer/CSR register files and the rename/scoreboard tables.

---
 rtl/asic_ram_nrmw_pkg.sv | 17 +
 rtl/asic_ram_nrmw_if.sv | 31 +++
 rtl/asic_ram_nrmw_wsel.sv | 28 ++
 rtl/asic_ram_nrmw.sv | 160 ++++++++++++++++
 tb/tb_asic_ram_nrmw.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/asic_ram_nrmw_pkg.sv
// Shared types and helpers for the multi-port register-file RAM.
// Clear-engine state encoding and address-width derivation.
package asic_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  function automatic int aw_of(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/asic_ram_nrmw_if.sv
// Bus bundle for asic_ram_nrmw: read/write ports and clear handshake.
// Master drives addresses, data and requests; slave is the RAM.
interface asic_ram_nrmw_if
  import asic_ram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NR    = 6,
  parameter int NW    = 2
);
  localparam int AW = aw_of(DEPTH);

  logic [NR*AW-1:0]    raddr;
  logic [NR*WIDTH-1:0] rdata;
  logic [NW*AW-1:0]    waddr;
  logic [NW*WIDTH-1:0] wdata;
  logic [NW-1:0]       we;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  modport master (
    output raddr, waddr, wdata, we, clr_req,
    input  rdata, clr_busy, clr_done
  );

  modport slave (
    input  raddr, waddr, wdata, we, clr_req,
    output rdata, clr_busy, clr_done
  );
endinterface

// File: rtl/asic_ram_nrmw_wsel.sv
// Write-port priority select for one target address.
// Highest-index enabled port matching the address wins.
module asic_ram_wsel #(
  parameter int WIDTH = 32,
  parameter int AW    = 4,
  parameter int NW    = 2
) (
  input  logic [NW*AW-1:0]    waddr,
  input  logic [NW*WIDTH-1:0] wdata,
  input  logic [NW-1:0]       we,
  input  logic [AW-1:0]       addr,
  output logic                hit,
  output logic [WIDTH-1:0]    data
);

  // Scan upward so later (higher) ports override earlier matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NW; j++) begin
      if (we[j] && (waddr[j*AW +: AW] == addr)) begin
        hit  = 1'b1;
        data = wdata[j*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/asic_ram_nrmw.sv
// Parametrised NR-read / NW-write register-file RAM with bypass,
// optional registered reads, hardwired zero entry and clear engine.
module asic_ram_nrmw
  import asic_ram_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int NR        = 6,
  parameter int NW        = 2,
  parameter bit RESET_ALL = 1'b0,
  parameter bit R0_ZERO   = 1'b1,
  parameter bit BYPASS    = 1'b1,
  parameter bit READ_REG  = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  asic_ram_nrmw_if.slave  bus
);

  localparam int AW = aw_of(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  clr_state_t       state;
  logic [AW-1:0]    ptr;
  logic             busy;
  logic             done;
  logic             clearing;

  assign clearing     = (state == CLEAR);
  assign bus.clr_busy = busy;
  assign bus.clr_done = done;

  // Clear engine: walk ptr over every entry, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == AW'(DEPTH - 1)) begin
            state <= DONE;
            ptr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    if (R0_ZERO && (e == 0)) begin : g_zero
      assign mem[e] = '0;
    end else begin : g_store
      logic             hit;
      logic             zap;
      logic [WIDTH-1:0] val;
      logic [WIDTH-1:0] q;

      asic_ram_wsel #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .NW    (NW)
      ) u_wsel (
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .we    (bus.we),
        .addr  (AW'(e)),
        .hit   (hit),
        .data  (val)
      );

      assign zap    = clearing && (ptr == AW'(e));
      assign mem[e] = q;

      if (RESET_ALL || (e == 0)) begin : g_rst
        // Resettable entry: a write beats the clear zero.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)   q <= '0;
          else if (hit) q <= val;
          else if (zap) q <= '0;
        end
      end else begin : g_nrst
        // Unreset entry: frozen while reset is held.
        always_ff @(posedge clk) begin
          if (rst_n) begin
            if (hit)      q <= val;
            else if (zap) q <= '0;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             hit;
    logic [WIDTH-1:0] bval;
    logic [WIDTH-1:0] v;

    assign ra = bus.raddr[i*AW +: AW];

    asic_ram_wsel #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .NW    (NW)
    ) u_byp (
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .we    (bus.we),
      .addr  (ra),
      .hit   (hit),
      .data  (bval)
    );

    // Read value: range and zero-entry masking, then bypass, then store.
    always_comb begin
      v = '0;
      if (int'(ra) >= DEPTH)          v = '0;
      else if (R0_ZERO && (ra == '0)) v = '0;
      else if (BYPASS && hit)         v = bval;
      else                            v = mem[ra];
    end

    if (READ_REG) begin : g_reg
      logic [WIDTH-1:0] q;
      // One-cycle registered read data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= v;
      end
      assign bus.rdata[i*WIDTH +: WIDTH] = q;
    end else begin : g_comb
      assign bus.rdata[i*WIDTH +: WIDTH] = v;
    end
  end

endmodule

// File: tb/tb_asic_ram_nrmw.sv
// Directed bench for asic_ram_nrmw: three configurations covering
// bypass, zero entry, clear engine, reset behaviour and registered reads.
module tb_asic_ram_nrmw;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  asic_ram_nrmw_if #(.WIDTH(32), .DEPTH(16), .NR(6), .NW(2)) ia ();
  asic_ram_nrmw_if #(.WIDTH(32), .DEPTH(16), .NR(6), .NW(2)) ib ();
  asic_ram_nrmw_if #(.WIDTH(32), .DEPTH(12), .NR(6), .NW(2)) ic ();

  asic_ram_nrmw #(
    .WIDTH(32), .DEPTH(16), .NR(6), .NW(2),
    .RESET_ALL(1'b0), .R0_ZERO(1'b1), .BYPASS(1'b1), .READ_REG(1'b0)
  ) dut_a (.clk(clk), .rst_n(rst_a), .bus(ia.slave));

  asic_ram_nrmw #(
    .WIDTH(32), .DEPTH(16), .NR(6), .NW(2),
    .RESET_ALL(1'b0), .R0_ZERO(1'b0), .BYPASS(1'b0), .READ_REG(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_b), .bus(ib.slave));

  asic_ram_nrmw #(
    .WIDTH(32), .DEPTH(12), .NR(6), .NW(2),
    .RESET_ALL(1'b0), .R0_ZERO(1'b1), .BYPASS(1'b1), .READ_REG(1'b1)
  ) dut_c (.clk(clk), .rst_n(rst_c), .bus(ic.slave));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_a(input int p);
    return ia.rdata[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_b(input int p);
    return ib.rdata[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_c(input int p);
    return ic.rdata[p*32 +: 32];
  endfunction

  initial begin
    ia.raddr = '0; ia.waddr = '0; ia.wdata = '0; ia.we = '0; ia.clr_req = 1'b0;
    ib.raddr = '0; ib.waddr = '0; ib.wdata = '0; ib.we = '0; ib.clr_req = 1'b0;
    ic.raddr = '0; ic.waddr = '0; ic.wdata = '0; ic.we = '0; ic.clr_req = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_a_busy", 32'(ia.clr_busy), 32'd0);
    chk("rst_a_done", 32'(ia.clr_done), 32'd0);
    chk("rst_a_r0", rd_a(0), 32'd0);
    chk("rst_b_r0", rd_b(0), 32'd0);
    chk("rst_c_rdata", rd_c(0), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    tick();

    // B: asynchronous reset hits entry 0 only
    ib.we = 2'b11;
    ib.waddr[3:0] = 4'd0; ib.wdata[31:0]  = 32'hA5;
    ib.waddr[7:4] = 4'd3; ib.wdata[63:32] = 32'h11;
    tick();
    ib.we = 2'b00;
    ib.raddr[3:0] = 4'd0;
    ib.raddr[7:4] = 4'd3;
    #2;
    chk("b_pre_e0", rd_b(0), 32'hA5);
    rst_b = 1'b0;
    #1;
    chk("b_async_e0", rd_b(0), 32'h0);
    chk("b_keep_e3", rd_b(1), 32'h11);
    rst_b = 1'b1;
    tick();

    // B: no bypass, old value visible during same-address dual write
    ib.we = 2'b01;
    ib.waddr[3:0] = 4'd5; ib.wdata[31:0] = 32'h99;
    tick();
    ib.we = 2'b11;
    ib.waddr[3:0] = 4'd5; ib.wdata[31:0]  = 32'h1;
    ib.waddr[7:4] = 4'd5; ib.wdata[63:32] = 32'h2;
    ib.raddr[3:0] = 4'd5;
    #1;
    chk("b_nobyp_old", rd_b(0), 32'h99);
    tick();
    ib.we = 2'b00;
    #1;
    chk("b_dual_win", rd_b(0), 32'h2);

    // A: same-address dual write with bypass
    ia.we = 2'b11;
    ia.waddr[3:0] = 4'd5; ia.wdata[31:0]  = 32'h1;
    ia.waddr[7:4] = 4'd5; ia.wdata[63:32] = 32'h2;
    ia.raddr[3:0] = 4'd5;
    #1;
    chk("a_byp_dual", rd_a(0), 32'h2);
    tick();
    ia.we = 2'b00;
    #1;
    chk("a_dual_store", rd_a(0), 32'h2);

    // A: hardwired zero entry
    ia.we = 2'b01;
    ia.waddr[3:0] = 4'd0; ia.wdata[31:0] = 32'hFFFF_FFFF;
    ia.raddr = '0;
    #1;
    for (int p = 0; p < 6; p++) chk($sformatf("a_r0_same_p%0d", p), rd_a(p), 32'h0);
    tick();
    ia.we = 2'b00;
    #1;
    for (int p = 0; p < 6; p++) chk($sformatf("a_r0_after_p%0d", p), rd_a(p), 32'h0);

    // A: preload and full clear
    for (int k = 1; k < 16; k++) begin
      ia.we = 2'b01;
      ia.waddr[3:0] = 4'(k); ia.wdata[31:0] = 32'(k);
      tick();
    end
    ia.we = 2'b00;
    ia.raddr[3:0] = 4'd9;
    ia.raddr[7:4] = 4'd15;
    #1;
    chk("a_pre_e9", rd_a(0), 32'd9);
    chk("a_pre_e15", rd_a(1), 32'd15);
    ia.clr_req = 1'b1;
    tick();
    ia.clr_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      logic [31:0] e2;
      logic [31:0] e3;
      if (c == 9) begin
        ia.we = 2'b01;
        ia.waddr[3:0] = 4'd9; ia.wdata[31:0] = 32'h77;
      end else begin
        ia.we = 2'b00;
      end
      ia.raddr[11:8]  = 4'(c);
      ia.raddr[15:12] = (c == 0) ? 4'd0 : 4'(c - 1);
      e2 = (c == 0) ? 32'd0 : (c == 9) ? 32'h77 : 32'(c);
      e3 = (c == 10) ? 32'h77 : 32'd0;
      #2;
      chk($sformatf("clr_busy_c%0d", c), 32'(ia.clr_busy), 32'd1);
      chk($sformatf("clr_nodone_c%0d", c), 32'(ia.clr_done), 32'd0);
      chk($sformatf("clr_cur_c%0d", c), rd_a(2), e2);
      chk($sformatf("clr_prev_c%0d", c), rd_a(3), e3);
      tick();
    end
    ia.we = 2'b00;
    chk("clr_done_pulse", 32'(ia.clr_done), 32'd1);
    chk("clr_done_busy", 32'(ia.clr_busy), 32'd0);
    ia.clr_req = 1'b1;
    tick();
    ia.clr_req = 1'b0;
    chk("clr_done_drop", 32'(ia.clr_done), 32'd0);
    chk("clr_req_in_done_busy", 32'(ia.clr_busy), 32'd0);
    tick();
    chk("clr_idle_busy", 32'(ia.clr_busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      ia.raddr[3:0] = 4'(k);
      #1;
      chk($sformatf("clr_ent_%0d", k), rd_a(0), (k == 9) ? 32'h77 : 32'd0);
    end

    // A: reset mid-clear at ptr 6
    tick();
    for (int k = 1; k < 16; k++) begin
      ia.we = 2'b10;
      ia.waddr[7:4] = 4'(k); ia.wdata[63:32] = 32'h100 + 32'(k);
      tick();
    end
    ia.we = 2'b00;
    ia.clr_req = 1'b1;
    tick();
    ia.clr_req = 1'b0;
    repeat (6) tick();
    chk("mid_busy", 32'(ia.clr_busy), 32'd1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(ia.clr_busy), 32'd0);
    chk("mid_rst_done", 32'(ia.clr_done), 32'd0);
    #1;
    rst_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_nodone_%0d", c), 32'(ia.clr_done), 32'd0);
      chk($sformatf("mid_nobusy_%0d", c), 32'(ia.clr_busy), 32'd0);
    end
    for (int k = 0; k < 16; k++) begin
      ia.raddr[3:0] = 4'(k);
      #1;
      chk($sformatf("mid_ent_%0d", k), rd_a(0),
          (k < 6) ? 32'd0 : 32'h100 + 32'(k));
    end

    // C: registered reads, DEPTH=12
    ic.we = 2'b01;
    ic.waddr[3:0] = 4'd4; ic.wdata[31:0] = 32'h33;
    ic.raddr[3:0] = 4'd0;
    tick();
    ic.we = 2'b00;
    ic.raddr[3:0] = 4'd4;
    #2;
    chk("c_lat_before", rd_c(0), 32'h0);
    tick();
    chk("c_lat_after", rd_c(0), 32'h33);
    ic.raddr[3:0] = 4'd13;
    #2;
    chk("c_oor_hold", rd_c(0), 32'h33);
    tick();
    chk("c_oor_13", rd_c(0), 32'h0);
    ic.raddr[3:0] = 4'd4;
    tick();
    ic.raddr[3:0] = 4'd12;
    tick();
    chk("c_oor_12", rd_c(0), 32'h0);
    ic.we = 2'b01;
    ic.waddr[3:0] = 4'd7; ic.wdata[31:0] = 32'h44;
    ic.raddr[3:0] = 4'd7;
    #2;
    chk("c_byp_before", rd_c(0), 32'h0);
    tick();
    chk("c_byp_after", rd_c(0), 32'h44);
    ic.we = 2'b01;
    ic.waddr[3:0] = 4'd13; ic.wdata[31:0] = 32'h55;
    ic.raddr[7:4] = 4'd13;
    tick();
    ic.we = 2'b00;
    chk("c_wr_oor", rd_c(1), 32'h0);
    chk("c_keep_7", rd_c(0), 32'h44);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
